// File: rtl/read_word_assembler.sv
// read_word_assembler
//
// Pairs 16-bit half-word reads from a synchronous-read memory into 32-bit words
// and queues them in a small first-word-fall-through FIFO.
//
// The upstream address generator drives addr_in/en. Read data for that address
// comes back one cycle later, so addr_in/en are registered (addr_d/en_d) to line
// up with rd_data. A two-state pair FSM holds a low half until the matching high
// half arrives, then pushes {high, low} with the word address into the FIFO.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          capture enable, aligned with addr_in
//   addr_in     half-word address; bit 0 = half select, bits 6:1 = word address
//   rd_data     memory read data, valid one cycle after its addr_in
//   word_out    FIFO head word {high, low}; 0 when the FIFO is empty
//   word_addr   word address of the FIFO head; 0 when the FIFO is empty
//   word_valid  FIFO non-empty
//   word_ready  consumer accepts the head when word_valid is also 1
//   overflow    sticky: a completed word was dropped because the FIFO was full
//   clr_ovf     synchronous clear of overflow (a same-cycle drop wins)
//   fifo_count  number of stored words

module read_word_assembler #(
    parameter int unsigned DEPTH      = 4,
    parameter bit          ADDR_MATCH = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [6:0]             addr_in,
    input  logic [15:0]            rd_data,
    output logic [31:0]            word_out,
    output logic [5:0]             word_addr,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned EW = 6 + 32;  // stored entry: {word address, high, low}

    localparam logic [PW:0]   FULL_COUNT = DEPTH[PW:0];
    localparam logic [PW:0]   COUNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    typedef enum logic [0:0] {
        StIdle,
        StHaveLo
    } state_t;

    // ------------------------------------------------------------------
    // Alignment stage: rd_data in cycle t belongs to addr_d in cycle t.
    // ------------------------------------------------------------------
    logic [6:0] addr_d;
    logic       en_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_d <= '0;
            en_d   <= 1'b0;
        end else begin
            addr_d <= addr_in;
            en_d   <= en;
        end
    end

    // ------------------------------------------------------------------
    // Pair FSM
    // ------------------------------------------------------------------
    state_t      state, state_next;
    logic [15:0] lo_data, lo_data_next;
    logic [5:0]  lo_addr, lo_addr_next;
    logic        push;
    logic        addr_ok;

    // With matching disabled any high half completes the held low half.
    assign addr_ok = !ADDR_MATCH || (addr_d[6:1] == lo_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            lo_data <= '0;
            lo_addr <= '0;
        end else begin
            state   <= state_next;
            lo_data <= lo_data_next;
            lo_addr <= lo_addr_next;
        end
    end

    always_comb begin
        state_next   = state;
        lo_data_next = lo_data;
        lo_addr_next = lo_addr;
        push         = 1'b0;

        unique case (state)
            StIdle: begin
                // A high half with no held low half is simply ignored.
                if (en_d && !addr_d[0]) begin
                    lo_data_next = rd_data;
                    lo_addr_next = addr_d[6:1];
                    state_next   = StHaveLo;
                end
            end

            StHaveLo: begin
                if (!en_d) begin
                    state_next = StIdle;
                end else if (!addr_d[0]) begin
                    // A newer low half replaces the held one.
                    lo_data_next = rd_data;
                    lo_addr_next = addr_d[6:1];
                end else if (addr_ok) begin
                    push       = 1'b1;
                    state_next = StIdle;
                end else begin
                    state_next = StIdle;
                end
            end

            default: state_next = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [EW-1:0] head;
    logic          full;
    logic          pop;
    logic          push_accept;
    logic          drop;

    assign full = (count == FULL_COUNT);
    assign pop  = word_valid && word_ready;

    // When full, a same-cycle pop frees the head slot, which is exactly the slot
    // the write pointer addresses, so the push can still be taken.
    assign push_accept = push && (!full || pop);
    assign drop        = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem[wr_ptr] <= {lo_addr, rd_data, lo_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            unique case ({push_accept, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase

            // Set has priority over clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign word_valid = (count != '0);

    // Gate the head so outputs read 0 while empty (and during reset), since the
    // storage array itself is not reset.
    assign word_out  = word_valid ? head[31:0]  : '0;
    assign word_addr = word_valid ? head[37:32] : '0;

endmodule

// File: tb/tb_read_word_assembler.sv
module tb_read_word_assembler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [6:0]  addr_in;
    logic [15:0] rd_data = '0;
    logic        word_ready;
    logic        clr_ovf;
    logic        nm_on;
    logic        en_nm;
    logic        ready_nm = 1'b1;

    logic [31:0] word_out;
    logic [5:0]  word_addr;
    logic        word_valid;
    logic        overflow;
    logic [2:0]  fifo_count;

    logic [31:0] nm_word_out;
    logic [5:0]  nm_word_addr;
    logic        nm_word_valid;
    logic        nm_overflow;
    logic [2:0]  nm_fifo_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem_h [128];
    logic [37:0] exp_q  [$];
    logic [37:0] exp_nm [$];

    assign en_nm = en && nm_on;

    read_word_assembler #(
        .DEPTH      (4),
        .ADDR_MATCH (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .addr_in    (addr_in),
        .rd_data    (rd_data),
        .word_out   (word_out),
        .word_addr  (word_addr),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .fifo_count (fifo_count)
    );

    read_word_assembler #(
        .DEPTH      (4),
        .ADDR_MATCH (1'b0)
    ) dut_nm (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_nm),
        .addr_in    (addr_in),
        .rd_data    (rd_data),
        .word_out   (nm_word_out),
        .word_addr  (nm_word_addr),
        .word_valid (nm_word_valid),
        .word_ready (ready_nm),
        .overflow   (nm_overflow),
        .clr_ovf    (clr_ovf),
        .fifo_count (nm_fifo_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data for addr_in appears one cycle later.
    always @(posedge clk) rd_data <= mem_h[addr_in];

    // Monitors: pop the expected entry whenever a word is accepted.
    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL dut_word: got addr=%h word=%h, none expected", word_addr, word_out);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                if ({word_addr, word_out} !== e) begin
                    bad++;
                    $display("FAIL dut_word: got addr=%h word=%h, expected addr=%h word=%h",
                             word_addr, word_out, e[37:32], e[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && nm_word_valid && ready_nm) begin
            total++;
            if (exp_nm.size() == 0) begin
                bad++;
                $display("FAIL nm_word: got addr=%h word=%h, none expected",
                         nm_word_addr, nm_word_out);
            end else begin
                logic [37:0] e;
                e = exp_nm.pop_front();
                if ({nm_word_addr, nm_word_out} !== e) begin
                    bad++;
                    $display("FAIL nm_word: got addr=%h word=%h, expected addr=%h word=%h",
                             nm_word_addr, nm_word_out, e[37:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [6:0] a);
        en      = e;
        addr_in = a;
        cyc();
    endtask

    // Issue both halves of word w back to back.
    task automatic send_word(input logic [5:0] w);
        drive(1'b1, {w, 1'b0});
        drive(1'b1, {w, 1'b1});
    endtask

    function automatic logic [37:0] exp_word(input logic [5:0] w);
        logic [6:0] lo_a;
        logic [6:0] hi_a;
        lo_a = {w, 1'b0};
        hi_a = {w, 1'b1};
        return {w, mem_h[hi_a], mem_h[lo_a]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 128; a++) begin
            logic [6:0] a7;
            a7 = 7'(a);
            mem_h[a] = {8'hC3, 1'b0, a7};
        end
        mem_h[7'h0A] = 16'h1234;
        mem_h[7'h0B] = 16'hABCD;

        rst_n      = 1'b0;
        en         = 1'b0;
        addr_in    = '0;
        word_ready = 1'b1;
        clr_ovf    = 1'b0;
        nm_on      = 1'b0;

        // Reset state
        cyc();
        cyc();
        check("rst_valid", 64'(word_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_word", 64'({word_addr, word_out}), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Basic pair: 0x0A/0x0B -> 0xABCD1234 at word 0x05, visible for one cycle
        exp_q.push_back({6'h05, 32'hABCD1234});
        drive(1'b1, 7'h0A);
        drive(1'b1, 7'h0B);
        drive(1'b0, 7'h00);
        check("basic_valid_on", 64'(word_valid), 64'd1);
        cyc();
        check("basic_valid_off", 64'(word_valid), 64'd0);

        // Fill with ready low: 5 words, only the first 4 are kept
        word_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            logic [5:0] w;
            w = 6'h10 + 6'(k);
            if (k < 4) exp_q.push_back(exp_word(w));
            send_word(w);
        end
        en = 1'b0;
        cyc();
        cyc();
        check("fill_count", 64'(fifo_count), 64'd4);
        check("fill_ovf", 64'(overflow), 64'd1);

        // Drop coinciding with clr_ovf: set wins
        send_word(6'h15);
        en      = 1'b0;
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        check("set_wins_ovf", 64'(overflow), 64'd1);
        check("set_wins_count", 64'(fifo_count), 64'd4);

        word_ready = 1'b1;
        repeat (4) cyc();
        check("drain_count", 64'(fifo_count), 64'd0);
        check("drain_valid", 64'(word_valid), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        check("clr_ovf", 64'(overflow), 64'd0);

        // Full FIFO with a pop in the push cycle: nothing lost
        word_ready = 1'b0;
        for (int k = 0; k < 5; k++) exp_q.push_back(exp_word(6'h18 + 6'(k)));
        for (int k = 0; k < 4; k++) send_word(6'h18 + 6'(k));
        en = 1'b0;
        cyc();
        cyc();
        check("full_count", 64'(fifo_count), 64'd4);
        send_word(6'h1C);
        en         = 1'b0;
        word_ready = 1'b1;
        cyc();
        word_ready = 1'b0;
        check("pushpop_count", 64'(fifo_count), 64'd4);
        check("pushpop_ovf", 64'(overflow), 64'd0);
        word_ready = 1'b1;
        repeat (4) cyc();
        check("pushpop_drain", 64'(fifo_count), 64'd0);

        // Address mismatch: dut drops, no-match instance pushes
        nm_on = 1'b1;
        exp_nm.push_back({6'h05, 16'hC30D, 16'h1234});
        drive(1'b1, 7'h0A);
        drive(1'b1, 7'h0D);
        drive(1'b0, 7'h00);
        nm_on = 1'b0;
        // Lone matching high half: pushes only if the FSM wrongly kept the low half
        drive(1'b1, 7'h0B);
        drive(1'b0, 7'h00);
        cyc();
        check("mismatch_count", 64'(fifo_count), 64'd0);
        check("nm_count", 64'(nm_fifo_count), 64'd0);

        // Low half replaced by a newer low half
        exp_q.push_back({6'h11, 16'hC323, 16'hC322});
        drive(1'b1, 7'h20);
        drive(1'b1, 7'h22);
        drive(1'b1, 7'h23);
        drive(1'b0, 7'h00);
        cyc();

        // en dropped between halves, then a stream starting on a high half
        drive(1'b1, 7'h30);
        drive(1'b0, 7'h31);
        drive(1'b1, 7'h31);
        drive(1'b0, 7'h00);
        cyc();
        check("en_drop_count", 64'(fifo_count), 64'd0);
        exp_q.push_back({6'h1A, 16'hC335, 16'hC334});
        drive(1'b1, 7'h33);
        drive(1'b1, 7'h34);
        drive(1'b1, 7'h35);
        drive(1'b0, 7'h00);
        cyc();
        cyc();

        // Reset with 3 stored words and a low half held
        word_ready = 1'b0;
        send_word(6'h38);
        send_word(6'h39);
        send_word(6'h3A);
        drive(1'b1, 7'h76);
        en = 1'b0;
        cyc();
        check("pre_rst_count", 64'(fifo_count), 64'd3);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(word_valid), 64'd0);
        check("async_rst_word", 64'({word_addr, word_out}), 64'd0);
        check("async_rst_count", 64'(fifo_count), 64'd0);
        check("async_rst_ovf", 64'(overflow), 64'd0);
        cyc();
        cyc();
        rst_n      = 1'b1;
        word_ready = 1'b1;
        cyc();
        // High half matching the pre-reset low half must not complete a word
        drive(1'b1, 7'h77);
        drive(1'b0, 7'h00);
        cyc();
        check("post_rst_count", 64'(fifo_count), 64'd0);
        exp_q.push_back(exp_word(6'h3C));
        send_word(6'h3C);
        drive(1'b0, 7'h00);
        repeat (3) cyc();

        check("dut_queue_empty", 64'(exp_q.size()), 64'd0);
        check("nm_queue_empty", 64'(exp_nm.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
